// File: rtl/texture_loader.sv
// Texture BRAM loader: splits one load command into read bursts and writes each returned texel.
// Optional TEXTURE_LOADER_CHECKSUM_EN adds a rolling 16-bit checksum of written texels.
module texture_loader #(
    parameter int ADDR_BITS  = 12,
    parameter int MEM_ADDR_W = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MEM_ADDR_W-1:0] cmd_mem_base,
    input  logic [ADDR_BITS-1:0]  cmd_tex_addr,
    input  logic [ADDR_BITS:0]    cmd_count,
    input  logic                  abort,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [MEM_ADDR_W-1:0] mem_req_addr,
    output logic [7:0]            mem_req_len,
    input  logic                  mem_rsp_valid,
    input  logic [15:0]           mem_rsp_data,
    output logic [ADDR_BITS-1:0]  tex_wr_addr,
    output logic [15:0]           tex_wr_data,
    output logic                  tex_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
`ifdef TEXTURE_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DONE, S_ABORT} state_t;

    localparam logic [ADDR_BITS:0] BURST_W = (ADDR_BITS+1)'(BURST_LEN);

    state_t                state, state_nx;
    logic [MEM_ADDR_W-1:0] byte_addr;
    logic [ADDR_BITS-1:0]  tex_idx;
    logic [ADDR_BITS:0]    remaining;
    logic [8:0]            beats_left;
    logic                  draining;
    logic [ADDR_BITS:0]    burst_cnt;
    logic [7:0]            req_len;
    logic                  last_beat;

    always_comb begin
        burst_cnt = remaining;
        if (remaining >= BURST_W)
            burst_cnt = BURST_W;
        req_len = 8'(burst_cnt - 1'b1);
    end

    assign last_beat = mem_rsp_valid && (beats_left == 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nx = (cmd_count == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                // An accepted request always wins over abort: the burst must be drained.
                if (mem_req_ready)
                    state_nx = S_DATA;
                else if (abort)
                    state_nx = S_ABORT;
            end
            S_DATA: begin
                if (last_beat) begin
                    if (draining || abort)
                        state_nx = S_ABORT;
                    else if (remaining != {{ADDR_BITS{1'b0}}, 1'b1})
                        state_nx = S_REQ;
                    else
                        state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ABORT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_addr   <= '0;
            tex_idx     <= '0;
            remaining   <= '0;
            beats_left  <= '0;
            draining    <= 1'b0;
            tex_wr_en   <= 1'b0;
            tex_wr_addr <= '0;
            tex_wr_data <= '0;
        end else begin
            tex_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        byte_addr <= {cmd_mem_base[MEM_ADDR_W-1:1], 1'b0};
                        tex_idx   <= cmd_tex_addr;
                        remaining <= cmd_count;
                        draining  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        beats_left <= {1'b0, req_len} + 9'd1;
                        draining   <= abort;
                    end
                end
                S_DATA: begin
                    if (abort)
                        draining <= 1'b1;
                    if (mem_rsp_valid) begin
                        beats_left <= beats_left - 9'd1;
                        remaining  <= remaining - 1'b1;
                        byte_addr  <= byte_addr + MEM_ADDR_W'(2);
                        tex_idx    <= tex_idx + 1'b1;
                        // Beats arriving with or after an abort are absorbed, not written.
                        if (!draining && !abort) begin
                            tex_wr_en   <= 1'b1;
                            tex_wr_addr <= tex_idx;
                            tex_wr_data <= mem_rsp_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = (state == S_REQ) ? byte_addr : '0;
    assign mem_req_len   = (state == S_REQ) ? req_len : '0;
    assign done          = (state == S_DONE);
    assign aborted       = (state == S_ABORT);

`ifdef TEXTURE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum <= '0;
        else if (state == S_IDLE && cmd_valid)
            checksum <= '0;
        else if (tex_wr_en)
            checksum <= {checksum[14:0], checksum[15]} ^ tex_wr_data;
    end
`endif

endmodule

// File: tb/tb_texture_loader.sv
// Scoreboard bench for texture_loader: expected writes queued as beats are driven, popped on tex_wr_en.
module tb_texture_loader;
    localparam int AB = 12;
    localparam int MW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [MW-1:0] cmd_mem_base = '0;
    logic [AB-1:0] cmd_tex_addr = '0;
    logic [AB:0]   cmd_count = '0;
    logic          abort = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [MW-1:0] mem_req_addr;
    logic [7:0]    mem_req_len;
    logic          mem_rsp_valid = 1'b0;
    logic [15:0]   mem_rsp_data = '0;
    logic [AB-1:0] tex_wr_addr;
    logic [15:0]   tex_wr_data;
    logic          tex_wr_en;
    logic          busy, done, aborted;
`ifdef TEXTURE_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    always #5 clk = ~clk;

    texture_loader #(.ADDR_BITS(AB), .MEM_ADDR_W(MW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mem_base(cmd_mem_base),
        .cmd_tex_addr(cmd_tex_addr), .cmd_count(cmd_count), .abort(abort),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .tex_wr_addr(tex_wr_addr), .tex_wr_data(tex_wr_data), .tex_wr_en(tex_wr_en),
        .busy(busy), .done(done), .aborted(aborted)
`ifdef TEXTURE_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [AB+15:0] exp_q[$];
    logic [AB-1:0]  exp_tex;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
            if (tex_wr_en) begin
                wr_cnt++;
                chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    chk("wr_addr_data", {tex_wr_addr, tex_wr_data}, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [MW-1:0] base, input logic [AB-1:0] ta, input logic [AB:0] cnt);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_mem_base = base; cmd_tex_addr = ta; cmd_count = cnt;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_tex = ta;
    endtask

    task automatic req_handshake(input logic [MW-1:0] addr, input logic [7:0] len, input int stall);
        int n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, addr);
        chk("req_len", mem_req_len, len);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("req_hold", {mem_req_valid, mem_req_addr, mem_req_len}, {1'b1, addr, len});
        end
        @(posedge clk); #1 mem_req_ready = 1'b1;
        @(posedge clk); #1 mem_req_ready = 1'b0;
    endtask

    task automatic beats(input int n, input logic [15:0] d0, input bit push);
        for (int i = 0; i < n; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = d0 + 16'(i);
            if (push) exp_q.push_back({exp_tex, mem_rsp_data});
            exp_tex++;
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic finish_ok(input string tag);
        @(negedge clk);
        chk({tag, "_done_last_wr"}, {done, tex_wr_en, aborted}, 3'b110);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, cmd_ready, done}, 3'b010);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0;
        #12;
        chk("reset_outs", {cmd_ready, busy, mem_req_valid, tex_wr_en, done, aborted}, 6'b100000);
        @(posedge clk); #1 rst_n = 1'b1;

        // stray beat while idle
        @(posedge clk); #1 mem_rsp_valid = 1'b1; mem_rsp_data = 16'hdead;
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spurious_idle", tex_wr_en, 0);

        // single full burst
        wr_cnt = 0;
        send_cmd(32'h1000, 12'd0, 13'd16);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        req_handshake(32'h1000, 8'd15, 0);
        beats(16, 16'h0001, 1);
        finish_ok("t1");
        chk("t1_wr_cnt", wr_cnt, 16);

        // three bursts, stalled first request, odd base address
        wr_cnt = 0;
        send_cmd(32'h1001, 12'd100, 13'd40);
        req_handshake(32'h1000, 8'd15, 3);
        beats(16, 16'h0100, 1);
        req_handshake(32'h1020, 8'd15, 0);
        beats(16, 16'h0200, 1);
        req_handshake(32'h1040, 8'd7, 0);
        beats(8, 16'h0300, 1);
        finish_ok("t2");
        chk("t2_wr_cnt", wr_cnt, 40);

        // zero-length load
        d0 = done_cnt;
        send_cmd(32'h4000, 12'd0, 13'd0);
        @(negedge clk);
        chk("t4_done", {done, mem_req_valid, busy}, 3'b101);
        @(negedge clk);
        chk("t4_idle", {done, mem_req_valid, cmd_ready}, 3'b001);
        chk("t4_done_cnt", done_cnt - d0, 1);

        // abort mid-burst: 5 written, 11 absorbed
        wr_cnt = 0; d0 = done_cnt; a0 = abort_cnt;
        send_cmd(32'h3000, 12'd200, 13'd16);
        req_handshake(32'h3000, 8'd15, 0);
        beats(5, 16'h0500, 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        beats(11, 16'h0600, 0);
        @(negedge clk);
        chk("t5_aborted", {aborted, done, busy}, 3'b101);
        @(negedge clk);
        chk("t5_idle", {cmd_ready, busy, aborted}, 3'b100);
        chk("t5_wr_cnt", wr_cnt, 5);
        chk("t5_abort_cnt", abort_cnt - a0, 1);
        chk("t5_no_done", done_cnt - d0, 0);

        // abort while request pending
        a0 = abort_cnt;
        send_cmd(32'h5000, 12'd0, 13'd8);
        @(negedge clk);
        chk("t5b_req", mem_req_valid, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t5b_abort", {mem_req_valid, aborted, busy}, 3'b011);
        @(negedge clk);
        chk("t5b_idle", {cmd_ready, busy}, 2'b10);

        // wrap past top of texture memory
        wr_cnt = 0;
        send_cmd(32'h2000, 12'd4094, 13'd4);
        req_handshake(32'h2000, 8'd3, 1);
        beats(4, 16'ha000, 1);
        finish_ok("t3");
        chk("t3_wr_cnt", wr_cnt, 4);

        // reset mid-burst
        send_cmd(32'h6000, 12'd10, 13'd16);
        req_handshake(32'h6000, 8'd15, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h0aa1;
        exp_q.push_back({exp_tex, mem_rsp_data}); exp_tex++;
        @(posedge clk); #1 mem_rsp_data = 16'h0aa2;
        exp_q.push_back({exp_tex, mem_rsp_data});
        @(posedge clk); #1 rst_n = 1'b0; mem_rsp_valid = 1'b0;
        #2;
        chk("t6_reset_outs", {cmd_ready, busy, mem_req_valid, tex_wr_en, done, aborted}, 6'b100000);
`ifdef TEXTURE_LOADER_CHECKSUM_EN
        chk("t6_checksum_rst", checksum, 0);
`endif
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        wr_cnt = 0;
        repeat (3) @(negedge clk);
        chk("t6_no_wr_after_rst", wr_cnt, 0);

        // checksum pattern
        send_cmd(32'h7000, 12'd0, 13'd2);
        req_handshake(32'h7000, 8'd1, 0);
        beats(1, 16'h8001, 1);
        beats(1, 16'h0003, 1);
        finish_ok("t7");
`ifdef TEXTURE_LOADER_CHECKSUM_EN
        chk("t7_checksum", checksum, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
